// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   uart_state_e : receiver state encoding
//   DATA_BITS    : payload bits per frame (8N1)
//   ACC_W        : width of the fractional baud accumulator
//   mid_tick()   : tick index of a bit centre for a given oversample ratio
//   tick_inc()   : accumulator increment for a given baud and oversample ratio
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned ACC_W     = 32;

    function automatic int unsigned mid_tick(input int unsigned oversample);
        return oversample / 2;
    endfunction

    // Both operands are elaboration constants; the product must stay below 2^31.
    function automatic int unsigned tick_inc(input int unsigned baud,
                                             input int unsigned oversample);
        return baud * oversample;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: fractional accumulator producing a single-cycle tick at
// RATE ticks per second from a CLK_HZ clock.
//   sys_clk_i : system clock
//   sys_rst_i : asynchronous active-high reset
//   tick_o    : one-cycle tick, mean spacing CLK_HZ/RATE cycles
`timescale 1ns/1ps
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned RATE   = 115200 * 16
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    output logic tick_o
);

    localparam logic [ACC_W-1:0] INC = ACC_W'(RATE);
    localparam logic [ACC_W-1:0] LIM = ACC_W'(CLK_HZ);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;

    // acc stays below LIM and INC < 2^31, so the sum never wraps.
    always_comb begin
        sum    = acc_q + INC;
        tick_o = (sum >= LIM);
        acc_d  = tick_o ? (sum - LIM) : sum;
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled with a 3-sample majority vote
// at each bit centre, and a valid/ack holding register towards the host.
//   sys_clk_i        : system clock
//   sys_rst_i        : asynchronous active-high reset
//   uart_rx_i        : serial line, asynchronous, idles high
//   uart_ack_i       : host consumes the held byte (only while valid)
//   uart_dat_o       : last accepted byte
//   uart_valid_o     : a byte is held and not yet acknowledged
//   uart_busy_o      : receiver is inside a frame
//   uart_frame_err_o : one-cycle pulse when the stop bit is sampled low
//   uart_overrun_o   : sticky, a byte completed while one was still held
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_i,
    input  logic                 uart_rx_i,
    input  logic                 uart_ack_i,
    output logic [DATA_BITS-1:0] uart_dat_o,
    output logic                 uart_valid_o,
    output logic                 uart_busy_o,
    output logic                 uart_frame_err_o,
    output logic                 uart_overrun_o
);

    localparam int unsigned MID      = mid_tick(OVERSAMPLE);
    localparam int unsigned TCNT_W   = $clog2(OVERSAMPLE);
    localparam int unsigned BITCNT_W = $clog2(DATA_BITS);

    // tcnt holds the number of ticks already seen in the state, so the k-th
    // tick arrives with tcnt_q == k-1. START centres on its MID-th tick;
    // DATA/STOP centres are OVERSAMPLE ticks after the previous centre.
    localparam logic [TCNT_W-1:0] START_C = TCNT_W'(MID - 1);
    localparam logic [TCNT_W-1:0] BIT_C   = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(DATA_BITS - 1);

    logic                 tick;
    logic                 sync1_q;
    logic                 rxs_q;
    uart_state_e          state_q, state_d;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
    logic [BITCNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] dat_q, dat_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic [TCNT_W-1:0]    c_pos;
    logic                 centre;
    logic                 vote;
    logic                 accept;

    uart_baud_tick #(
        .CLK_HZ (CLK_HZ),
        .RATE   (tick_inc(BAUD, OVERSAMPLE))
    ) u_tick (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .tick_o    (tick)
    );

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        samp_d      = samp_q;
        dat_d       = dat_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        accept      = 1'b0;

        c_pos  = (state_q == START) ? START_C : BIT_C;
        centre = tick && (tcnt_q == c_pos);
        vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);

        if (tick) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
            // The two ticks before the centre are stored; the third vote is live rxs.
            if (tcnt_q == c_pos - TCNT_W'(2)) samp_d[0] = rxs_q;
            if (tcnt_q == c_pos - TCNT_W'(1)) samp_d[1] = rxs_q;
        end

        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    tcnt_d  = '0;
                end
            end
            START: begin
                if (centre) begin
                    tcnt_d   = '0;
                    bitcnt_d = '0;
                    state_d  = vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (centre) begin
                    tcnt_d   = '0;
                    shift_d  = {vote, shift_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + BITCNT_W'(1);
                    if (bitcnt_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                if (centre) begin
                    tcnt_d = '0;
                    if (vote) begin
                        accept  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Held low (break): wait for the line to recover before re-arming.
                if (rxs_q) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                tcnt_d  = '0;
            end
        endcase

        if (uart_ack_i && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        // An ack in the same cycle frees the register for the new byte.
        if (accept) begin
            if (!valid_q || uart_ack_i) begin
                dat_d   = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= IDLE;
            tcnt_q      <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            samp_q      <= '0;
            dat_q       <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= uart_rx_i;
            rxs_q       <= sync1_q;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            samp_q      <= samp_d;
            dat_q       <= dat_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign uart_dat_o       = dat_q;
    assign uart_valid_o     = valid_q;
    assign uart_busy_o      = (state_q != IDLE);
    assign uart_frame_err_o = frame_err_q;
    assign uart_overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 50 MHz / 115200 8N1.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_NS = 8681;   // 1e9 / 115200
    localparam int TICK_NS = 543;   // one 16x tick, ~27.13 cycles of 20 ns

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] dat;
    logic       valid;
    logic       busy;
    logic       fe;
    logic       ovr;

    int errors = 0;
    int checks = 0;
    int fe_count = 0;

    uart_rx dut (
        .sys_clk_i        (clk),
        .sys_rst_i        (rst),
        .uart_rx_i        (rx),
        .uart_ack_i       (ack),
        .uart_dat_o       (dat),
        .uart_valid_o     (valid),
        .uart_busy_o      (busy),
        .uart_frame_err_o (fe),
        .uart_overrun_o   (ovr)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (fe === 1'b1) fe_count <= fe_count + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_v;
        #(bit_ns);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        #(n * BIT_NS);
    endtask

    task automatic wait_valid(input int max_cyc, output int cyc);
        cyc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                cyc = i + 1;
                break;
            end
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++; if (dat !== 8'h00) begin errors++; $display("FAIL reset_dat: got %h want 00", dat); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fe !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", fe); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", ovr); end
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int lat;
        logic prev_busy;
        logic busy_at;
        int fe0;
        fe0 = fe_count;
        lat = -1;
        prev_busy = 1'b0;
        busy_at = 1'b1;
        fork
            send_frame(8'h55, 1'b1, BIT_NS);
            begin
                for (int i = 0; i < 5000; i++) begin
                    @(posedge clk);
                    #1;
                    if (valid === 1'b1) begin
                        lat = i + 1;
                        busy_at = busy;
                        break;
                    end
                    prev_busy = busy;
                end
            end
        join
        // 9.5 bits (4123 cycles) + 3, within about one tick either way
        checks++; if (lat < 4090 || lat > 4160) begin errors++; $display("FAIL basic_latency: got %0d cycles want 4090..4160", lat); end
        checks++; if (dat !== 8'h55) begin errors++; $display("FAIL basic_dat: got %h want 55", dat); end
        checks++; if (prev_busy !== 1'b1 || busy_at !== 1'b0) begin errors++; $display("FAIL basic_busy_edge: before=%b at_valid=%b want 1/0", prev_busy, busy_at); end
        checks++; if (fe_count != fe0) begin errors++; $display("FAIL basic_frame_err: got %0d pulses want 0", fe_count - fe0); end
        do_ack();
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_ack: valid=%b want 0", valid); end
        idle_bits(1);
    endtask

    task automatic test_back_to_back();
        int c1;
        int c2;
        logic [7:0] d1;
        logic [7:0] d2;
        logic o2;
        fork
            begin
                send_frame(8'hA5, 1'b1, BIT_NS);
                send_frame(8'h3C, 1'b1, BIT_NS);
            end
            begin
                wait_valid(6000, c1);
                d1 = dat;
                do_ack();
                wait_valid(6000, c2);
                d2 = dat;
                o2 = ovr;
                do_ack();
            end
        join
        checks++; if (c1 < 0 || d1 !== 8'hA5) begin errors++; $display("FAIL b2b_first: got %h (wait %0d) want a5", d1, c1); end
        checks++; if (c2 < 0 || d2 !== 8'h3C) begin errors++; $display("FAIL b2b_second: got %h (wait %0d) want 3c", d2, c2); end
        checks++; if (o2 !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", o2); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_final_valid: got %b want 0", valid); end
        idle_bits(1);
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, BIT_NS);
        checks++; if (valid !== 1'b1 || dat !== 8'h11) begin errors++; $display("FAIL ovr_first: valid=%b dat=%h want 1/11", valid, dat); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", ovr); end
        idle_bits(1);
        send_frame(8'h22, 1'b1, BIT_NS);
        checks++; if (dat !== 8'h11) begin errors++; $display("FAIL ovr_dat_held: got %h want 11", dat); end
        checks++; if (ovr !== 1'b1 || valid !== 1'b1) begin errors++; $display("FAIL ovr_flag: ovr=%b valid=%b want 1/1", ovr, valid); end
        do_ack();
        #1;
        checks++; if (ovr !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL ovr_ack_clear: ovr=%b valid=%b want 0/0", ovr, valid); end
        idle_bits(1);
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_count;
        send_frame(8'h7E, 1'b0, BIT_NS);
        rx = 1'b0;
        #(3 * BIT_NS);
        checks++; if (fe_count - fe0 != 1) begin errors++; $display("FAIL fe_pulse: got %0d pulses want 1", fe_count - fe0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fe_valid: got %b want 0", valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fe_wait_high: busy=%b want 1", busy); end
        rx = 1'b1;
        #(BIT_NS);
        checks++; if (busy !== 1'b0 || fe_count - fe0 != 1) begin errors++; $display("FAIL fe_recover: busy=%b pulses=%0d want 0/1", busy, fe_count - fe0); end
        send_frame(8'h42, 1'b1, BIT_NS);
        checks++; if (valid !== 1'b1 || dat !== 8'h42) begin errors++; $display("FAIL fe_next: valid=%b dat=%h want 1/42", valid, dat); end
        do_ack();
        idle_bits(1);
    endtask

    task automatic test_glitch_and_reset();
        rx = 1'b0;
        #(4 * TICK_NS);
        rx = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start: busy=%b want 1", busy); end
        #(BIT_NS);
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL glitch_reject: busy=%b valid=%b want 0/0", busy, valid); end

        send_frame(8'h5A, 1'b1, BIT_NS);
        checks++; if (valid !== 1'b1 || dat !== 8'h5A) begin errors++; $display("FAIL rst_pre: valid=%b dat=%h want 1/5a", valid, dat); end
        idle_bits(1);
        rx = 1'b0;
        #(2 * BIT_NS);
        rx = 1'b1;
        #(BIT_NS / 2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (dat !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || ovr !== 1'b0 || fe !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: dat=%h valid=%b busy=%b ovr=%b fe=%b want all 0", dat, valid, busy, ovr, fe);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_bits(2);
        send_frame(8'h99, 1'b1, BIT_NS);
        checks++; if (valid !== 1'b1 || dat !== 8'h99) begin errors++; $display("FAIL rst_next: valid=%b dat=%h want 1/99", valid, dat); end
        do_ack();
        idle_bits(1);
    endtask

    task automatic test_baud_tolerance();
        int bits_ns [2];
        int fe0;
        bits_ns[0] = 8949;   // 111744 baud
        bits_ns[1] = 8428;   // 118656 baud
        for (int k = 0; k < 2; k++) begin
            fe0 = fe_count;
            send_frame(8'hC3, 1'b1, bits_ns[k]);
            idle_bits(1);
            checks++; if (valid !== 1'b1 || dat !== 8'hC3) begin errors++; $display("FAIL baud_%0d_dat: valid=%b dat=%h want 1/c3", bits_ns[k], valid, dat); end
            checks++; if (fe_count != fe0) begin errors++; $display("FAIL baud_%0d_frame_err: got %0d pulses want 0", bits_ns[k], fe_count - fe0); end
            do_ack();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch_and_reset();
        test_baud_tolerance();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
